// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register: opcode encoding, FSM states,
// default operand width and a small opcode classification helper.
package instr_register_pkg;

    localparam int DEFAULT_OP_WIDTH = 32;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        DIVIDE = 1'b1
    } state_t;

    // DIV and MOD go through the iterative divider; everything else is single-cycle.
    function automatic logic is_div_op(input opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage

// File: rtl/instr_div_unit.sv
// Restoring divider on operand magnitudes with sign correction at the output.
// The first quotient bit is resolved while loading, so OP_WIDTH bits are done
// after OP_WIDTH-1 further edges and done is seen at the following edge.
module instr_div_unit
    import instr_register_pkg::*;
#(
    parameter  int OP_WIDTH  = DEFAULT_OP_WIDTH,
    localparam int RES_WIDTH = 2 * OP_WIDTH,
    localparam int CW        = $clog2(OP_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic signed [OP_WIDTH-1:0]  dividend,
    input  logic signed [OP_WIDTH-1:0]  divisor,
    input  logic                        is_mod,
    output logic                        done,
    output logic [RES_WIDTH-1:0]        result,
    output logic                        err
);

    logic                 busy_q, busy_d;
    logic [CW-1:0]        step_q, step_d;
    logic [OP_WIDTH-1:0]  rem_q, rem_d;
    logic [OP_WIDTH-1:0]  quo_q, quo_d;
    logic [OP_WIDTH-1:0]  dsr_q, dsr_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic                 mod_q, mod_d;
    logic                 zero_q, zero_d;
    logic [RES_WIDTH-1:0] sx_a_q, sx_a_d;

    logic [OP_WIDTH-1:0]  a_mag, b_mag;
    logic [RES_WIDTH-1:0] q_ext, r_ext;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. Returns {remainder, quotient}.
    function automatic logic [2*OP_WIDTH-1:0] div_step(
        input logic [OP_WIDTH-1:0] rem,
        input logic [OP_WIDTH-1:0] quo,
        input logic [OP_WIDTH-1:0] dsr
    );
        logic [OP_WIDTH:0]   r;
        logic [OP_WIDTH-1:0] q;
        r = {rem, quo[OP_WIDTH-1]};
        q = {quo[OP_WIDTH-2:0], 1'b0};
        if (r >= {1'b0, dsr}) begin
            r    = r - {1'b0, dsr};
            q[0] = 1'b1;
        end
        return {r[OP_WIDTH-1:0], q};
    endfunction

    assign done = busy_q && (step_q == CW'(OP_WIDTH));
    assign err  = zero_q;

    // Next-state for the iteration: abort wins, then load, then step until done.
    always_comb begin
        busy_d  = busy_q;
        step_d  = step_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        mod_d   = mod_q;
        zero_d  = zero_q;
        sx_a_d  = sx_a_q;
        a_mag   = dividend[OP_WIDTH-1] ? (~dividend + 1'b1) : dividend;
        b_mag   = divisor[OP_WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        if (abort) begin
            busy_d = 1'b0;
            step_d = '0;
        end else if (start) begin
            {rem_d, quo_d} = div_step('0, a_mag, b_mag);
            dsr_d   = b_mag;
            step_d  = CW'(1);
            busy_d  = 1'b1;
            q_neg_d = dividend[OP_WIDTH-1] ^ divisor[OP_WIDTH-1];
            r_neg_d = dividend[OP_WIDTH-1];
            mod_d   = is_mod;
            zero_d  = (divisor == '0);
            sx_a_d  = {{OP_WIDTH{dividend[OP_WIDTH-1]}}, dividend};
        end else if (busy_q) begin
            if (done) begin
                busy_d = 1'b0;
                step_d = '0;
            end else begin
                {rem_d, quo_d} = div_step(rem_q, quo_q, dsr_q);
                step_d = step_q + 1'b1;
            end
        end
    end

    // Sign-correct the magnitudes; divide-by-zero returns fixed patterns.
    always_comb begin
        q_ext = {{OP_WIDTH{1'b0}}, quo_q};
        r_ext = {{OP_WIDTH{1'b0}}, rem_q};
        if (zero_q) begin
            result = mod_q ? sx_a_q : '1;
        end else if (mod_q) begin
            result = r_neg_q ? -r_ext : r_ext;
        end else begin
            result = q_neg_q ? -q_ext : q_ext;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            step_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            mod_q   <= 1'b0;
            zero_q  <= 1'b0;
            sx_a_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            mod_q   <= mod_d;
            zero_q  <= zero_d;
            sx_a_q  <= sx_a_d;
        end
    end

endmodule

// File: rtl/instr_register_div.sv
// Instruction register with an execute stage: ALU ops go through a one-entry
// stage register, DIV/MOD through the iterative divider. Registered reads.
//
// Write handshake: an instruction is accepted at a rising edge where
// wr_valid && wr_ready; the producer holds its fields stable while wr_valid=1
// and wr_ready=0. wr_ready depends only on state and clr, never on wr_valid.
module instr_register_div
    import instr_register_pkg::*;
#(
    parameter  int OP_WIDTH  = DEFAULT_OP_WIDTH,
    parameter  int DEPTH     = 32,
    localparam int AW        = $clog2(DEPTH),
    localparam int RES_WIDTH = 2 * OP_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [AW-1:0]              wr_addr,
    input  opcode_t                    opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic                       rd_en,
    input  logic [AW-1:0]              rd_addr,
    output logic                       rd_valid,
    output opcode_t                    rd_opcode,
    output logic [OP_WIDTH-1:0]        rd_operand_a,
    output logic [OP_WIDTH-1:0]        rd_operand_b,
    output logic [RES_WIDTH-1:0]       rd_result,
    output logic                       rd_entry_valid,
    output logic                       rd_err,
    output state_t                     dbg_state
);

    localparam int CNTW = $clog2(OP_WIDTH);

    typedef struct packed {
        logic                 vld;
        logic                 err;
        opcode_t              op;
        logic [OP_WIDTH-1:0]  a;
        logic [OP_WIDTH-1:0]  b;
        logic [RES_WIDTH-1:0] res;
    } entry_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                stg_vld_q, stg_vld_d;
    logic [AW-1:0]       stg_addr_q, stg_addr_d;
    entry_t              stg_q, stg_d;
    logic [AW-1:0]       dv_addr_q, dv_addr_d;
    opcode_t             dv_op_q, dv_op_d;
    logic [OP_WIDTH-1:0] dv_a_q, dv_a_d;
    logic [OP_WIDTH-1:0] dv_b_q, dv_b_d;
    entry_t              mem_q [DEPTH];
    entry_t              mem_d [DEPTH];
    entry_t              rd_q, rd_d;
    logic                rd_valid_q, rd_valid_d;

    logic                 accept;
    logic                 div_start;
    logic                 div_done;
    logic                 div_err;
    logic [RES_WIDTH-1:0] div_result;

    // Single-cycle arithmetic on operands sign-extended to the result width.
    function automatic logic [RES_WIDTH-1:0] alu(
        input opcode_t                    op,
        input logic signed [OP_WIDTH-1:0] a,
        input logic signed [OP_WIDTH-1:0] b
    );
        logic signed [RES_WIDTH-1:0] ax, bx, r;
        ax = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
        bx = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};
        case (op)
            PASSA:   r = ax;
            PASSB:   r = bx;
            ADD:     r = ax + bx;
            SUB:     r = ax - bx;
            MULT:    r = ax * bx;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign wr_ready  = (state_q == IDLE) && !clr;
    assign accept    = wr_valid && wr_ready;
    assign div_start = accept && is_div_op(opcode);
    assign dbg_state = state_q;

    instr_div_unit #(.OP_WIDTH(OP_WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (clr),
        .dividend (operand_a),
        .divisor  (operand_b),
        .is_mod   (opcode == MOD),
        .done     (div_done),
        .result   (div_result),
        .err      (div_err)
    );

    // FSM, stage register, storage writes and read capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stg_vld_d  = stg_vld_q;
        stg_addr_d = stg_addr_q;
        stg_d      = stg_q;
        dv_addr_d  = dv_addr_q;
        dv_op_d    = dv_op_q;
        dv_a_d     = dv_a_q;
        dv_b_d     = dv_b_q;
        mem_d      = mem_q;
        rd_d       = rd_q;
        rd_valid_d = rd_en;
        // Reads sample the pre-edge array, so same-edge writes/clr are not seen.
        if (rd_en) begin
            rd_d = mem_q[rd_addr];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            stg_vld_d = 1'b0;
            state_d   = IDLE;
            cnt_d     = '0;
        end else begin
            if (stg_vld_q) begin
                mem_d[stg_addr_q] = stg_q;
            end
            stg_vld_d = 1'b0;
            if (state_q == DIVIDE) begin
                cnt_d = cnt_q + 1'b1;
                if (div_done) begin
                    mem_d[dv_addr_q].vld = 1'b1;
                    mem_d[dv_addr_q].err = div_err;
                    mem_d[dv_addr_q].op  = dv_op_q;
                    mem_d[dv_addr_q].a   = dv_a_q;
                    mem_d[dv_addr_q].b   = dv_b_q;
                    mem_d[dv_addr_q].res = div_result;
                end
                if (cnt_q == CNTW'(OP_WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            if (accept) begin
                if (is_div_op(opcode)) begin
                    state_d   = DIVIDE;
                    cnt_d     = '0;
                    dv_addr_d = wr_addr;
                    dv_op_d   = opcode;
                    dv_a_d    = operand_a;
                    dv_b_d    = operand_b;
                end else begin
                    stg_vld_d  = 1'b1;
                    stg_addr_d = wr_addr;
                    stg_d.vld  = 1'b1;
                    stg_d.err  = 1'b0;
                    stg_d.op   = opcode;
                    stg_d.a    = operand_a;
                    stg_d.b    = operand_b;
                    stg_d.res  = alu(opcode, operand_a, operand_b);
                end
            end
        end
    end

    // State registers; reset empties everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stg_vld_q  <= 1'b0;
            stg_addr_q <= '0;
            stg_q      <= '0;
            dv_addr_q  <= '0;
            dv_op_q    <= ZERO;
            dv_a_q     <= '0;
            dv_b_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stg_vld_q  <= stg_vld_d;
            stg_addr_q <= stg_addr_d;
            stg_q      <= stg_d;
            dv_addr_q  <= dv_addr_d;
            dv_op_q    <= dv_op_d;
            dv_a_q     <= dv_a_d;
            dv_b_q     <= dv_b_d;
            mem_q      <= mem_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid       = rd_valid_q;
    assign rd_opcode      = rd_q.op;
    assign rd_operand_a   = rd_q.a;
    assign rd_operand_b   = rd_q.b;
    assign rd_result      = rd_q.res;
    assign rd_entry_valid = rd_q.vld;
    assign rd_err         = rd_q.err;

endmodule

// File: tb/tb_instr_register_div.sv
// Bench for instr_register_div: an 8-bit/32-entry instance carries the main
// directed sequence, a 16-bit/8-entry instance repeats the same-address read/write
// case. Expected read responses are queued when a read is issued and popped by
// per-instance monitors whenever rd_valid is seen.
module tb_instr_register_div;
    import instr_register_pkg::*;

    localparam int E1 = 2 + 3 + 8 + 8 + 16;
    localparam int E2 = 2 + 3 + 16 + 16 + 32;

    logic clk = 1'b0;
    logic reset;
    logic clr;

    logic          wr_valid, wr_ready, rd_en, rd_valid, rd_entry_valid, rd_err;
    logic [4:0]    wr_addr, rd_addr;
    opcode_t       opcode, rd_opcode;
    logic [7:0]    operand_a, operand_b, rd_operand_a, rd_operand_b;
    logic [15:0]   rd_result;
    state_t        dbg_state;

    logic          wr_valid2, wr_ready2, rd_en2, rd_valid2, rd_entry_valid2, rd_err2;
    logic [2:0]    wr_addr2, rd_addr2;
    opcode_t       opcode2, rd_opcode2;
    logic [15:0]   operand_a2, operand_b2, rd_operand_a2, rd_operand_b2;
    logic [31:0]   rd_result2;
    state_t        dbg_state2;

    int checks = 0;
    int errors = 0;
    int lows;

    logic [E1-1:0] exp_q[$];
    logic [E2-1:0] exp2_q[$];

    instr_register_div #(.OP_WIDTH(8), .DEPTH(32)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_opcode(rd_opcode),
        .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b), .rd_result(rd_result),
        .rd_entry_valid(rd_entry_valid), .rd_err(rd_err), .dbg_state(dbg_state)
    );

    instr_register_div #(.OP_WIDTH(16), .DEPTH(8)) dut2 (
        .clk(clk), .reset(reset), .clr(1'b0),
        .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_addr(wr_addr2), .opcode(opcode2),
        .operand_a(operand_a2), .operand_b(operand_b2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_valid(rd_valid2), .rd_opcode(rd_opcode2),
        .rd_operand_a(rd_operand_a2), .rd_operand_b(rd_operand_b2), .rd_result(rd_result2),
        .rd_entry_valid(rd_entry_valid2), .rd_err(rd_err2), .dbg_state(dbg_state2)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [E1-1:0] mk1(input logic v, input logic er, input opcode_t op,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic [15:0] r);
        return {v, er, op, a, b, r};
    endfunction

    function automatic logic [E2-1:0] mk2(input logic v, input logic er, input opcode_t op,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [31:0] r);
        return {v, er, op, a, b, r};
    endfunction

    // Monitors: pop one expectation per presented read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd1_unexpected", 1, 0);
            end else begin
                chk("rd1_data", {rd_entry_valid, rd_err, rd_opcode, rd_operand_a,
                                 rd_operand_b, rd_result}, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid2 === 1'b1) begin
            if (exp2_q.size() == 0) begin
                chk("rd2_unexpected", 1, 0);
            end else begin
                chk("rd2_data", {rd_entry_valid2, rd_err2, rd_opcode2, rd_operand_a2,
                                 rd_operand_b2, rd_result2}, exp2_q.pop_front());
            end
        end
    end

    // Driver tasks: called at #1 after a rising edge, return at #1 after the next.
    task automatic wr1(input logic [4:0] ad, input opcode_t op, input logic [7:0] a,
                       input logic [7:0] b);
        wr_valid = 1'b1; wr_addr = ad; opcode = op; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic rd1(input logic [4:0] ad, input logic [E1-1:0] e);
        rd_en = 1'b1; rd_addr = ad;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic wr2(input logic [2:0] ad, input opcode_t op, input logic [15:0] a,
                       input logic [15:0] b);
        wr_valid2 = 1'b1; wr_addr2 = ad; opcode2 = op; operand_a2 = a; operand_b2 = b;
        @(posedge clk); #1;
        wr_valid2 = 1'b0;
    endtask

    task automatic rd2(input logic [2:0] ad, input logic [E2-1:0] e);
        rd_en2 = 1'b1; rd_addr2 = ad;
        exp2_q.push_back(e);
        @(posedge clk); #1;
        rd_en2 = 1'b0;
    endtask

    // Counts sampled cycles with wr_ready low, bounded.
    task automatic wait_rdy(input bit sel, output int n);
        n = 0;
        while (((sel ? wr_ready2 : wr_ready) !== 1'b1) && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; opcode = ZERO; operand_a = '0; operand_b = '0;
        rd_en = 1'b0; rd_addr = '0;
        wr_valid2 = 1'b0; wr_addr2 = '0; opcode2 = ZERO; operand_a2 = '0; operand_b2 = '0;
        rd_en2 = 1'b0; rd_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_fields", {rd_entry_valid, rd_err, rd_opcode, rd_operand_a,
                              rd_operand_b, rd_result}, 0);
        reset = 1'b0;
        #1;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_state", dbg_state, IDLE);
        @(posedge clk); #1;

        // Every entry empty after reset.
        for (int i = 0; i < 32; i++) rd1(5'(i), '0);

        // Back-to-back ALU writes.
        chk("alu_rdy0", wr_ready, 1);
        wr1(5'd0, ADD, 8'h05, 8'hFD);
        chk("alu_rdy1", wr_ready, 1);
        wr1(5'd1, SUB, 8'h80, 8'h7F);
        chk("alu_rdy2", wr_ready, 1);
        wr1(5'd2, MULT, 8'h80, 8'h80);
        chk("alu_rdy3", wr_ready, 1);
        @(posedge clk); #1;
        rd1(5'd0, mk1(1, 0, ADD, 8'h05, 8'hFD, 16'h0002));
        rd1(5'd1, mk1(1, 0, SUB, 8'h80, 8'h7F, 16'hFF01));
        rd1(5'd2, mk1(1, 0, MULT, 8'h80, 8'h80, 16'h4000));

        // Signed DIV / MOD with busy-window length.
        wr1(5'd3, DIV, 8'hF9, 8'h02);
        wait_rdy(0, lows);
        chk("div_busy_cycles", lows, 8);
        wr1(5'd4, MOD, 8'hF9, 8'h02);
        wait_rdy(0, lows);
        chk("mod_busy_cycles", lows, 8);
        rd1(5'd3, mk1(1, 0, DIV, 8'hF9, 8'h02, 16'hFFFD));
        rd1(5'd4, mk1(1, 0, MOD, 8'hF9, 8'h02, 16'hFFFF));

        // Divide by zero and min / -1.
        wr1(5'd5, DIV, 8'h09, 8'h00);
        wait_rdy(0, lows);
        chk("divz_busy_cycles", lows, 8);
        wr1(5'd6, MOD, 8'h09, 8'h00);
        wait_rdy(0, lows);
        wr1(5'd8, DIV, 8'h80, 8'hFF);
        wait_rdy(0, lows);
        rd1(5'd5, mk1(1, 1, DIV, 8'h09, 8'h00, 16'hFFFF));
        rd1(5'd6, mk1(1, 1, MOD, 8'h09, 8'h00, 16'h0009));
        rd1(5'd8, mk1(1, 0, DIV, 8'h80, 8'hFF, 16'h0080));

        // clr three cycles into a DIV, with a same-edge read of old contents.
        wr1(5'd9, DIV, 8'h14, 8'h03);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1; rd_en = 1'b1; rd_addr = 5'd3;
        exp_q.push_back(mk1(1, 0, DIV, 8'hF9, 8'h02, 16'hFFFD));
        #1;
        chk("clr_rdy_low", wr_ready, 0);
        @(posedge clk); #1;
        clr = 1'b0; rd_en = 1'b0;
        #1;
        chk("clr_rdy_after", wr_ready, 1);
        chk("clr_state", dbg_state, IDLE);
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) rd1(5'(i), '0);

        // Reset in the middle of a DIV.
        wr1(5'd10, ADD, 8'h01, 8'h02);
        wr1(5'd11, DIV, 8'h14, 8'h03);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("rstdiv_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rstdiv_rdy", wr_ready, 1);
        chk("rstdiv_state", dbg_state, IDLE);
        repeat (10) @(posedge clk);
        #1;
        rd1(5'd10, '0);
        rd1(5'd11, '0);

        // Read at the storage-write edge returns old data, next read the new.
        wr1(5'd7, ADD, 8'h01, 8'h01);
        @(posedge clk); #1;
        wr1(5'd7, SUB, 8'h0A, 8'h03);
        rd1(5'd7, mk1(1, 0, ADD, 8'h01, 8'h01, 16'h0002));
        rd1(5'd7, mk1(1, 0, SUB, 8'h0A, 8'h03, 16'h0007));

        // Wider instance: reuse of the top address and a min / -1 divide.
        wr2(3'd7, MULT, 16'hFED4, 16'h00C8);
        @(posedge clk); #1;
        wr2(3'd7, SUB, 16'h8000, 16'h7FFF);
        rd2(3'd7, mk2(1, 0, MULT, 16'hFED4, 16'h00C8, 32'hFFFF15A0));
        rd2(3'd7, mk2(1, 0, SUB, 16'h8000, 16'h7FFF, 32'hFFFF0001));
        wr2(3'd0, DIV, 16'h8000, 16'hFFFF);
        wait_rdy(1, lows);
        chk("div16_busy_cycles", lows, 16);
        rd2(3'd0, mk2(1, 0, DIV, 16'h8000, 16'hFFFF, 32'h00008000));
        rd2(3'd3, '0);

        repeat (3) @(posedge clk);
        #1;
        chk("drain1", exp_q.size(), 0);
        chk("drain2", exp2_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
